// File: rtl/led_pkg.sv
// led_pkg: shared channel state encoding and default timing constants for the LED fader.
package led_pkg;
    typedef enum logic [1:0] {OFF, RISING, ON, FALLING} ch_state_t;
    localparam int DEF_PRESC        = 50;
    localparam int DEF_PWM_BITS     = 8;
    localparam int DEF_STEP_PERIODS = 4;
endpackage

// File: rtl/led_fade_ch.sv
// led_fade_ch: one LED channel -- fade FSM, saturating duty register and PWM compare.
// Define LED_FADE_GAMMA_EN for a squared (gamma) duty curve; otherwise duty is linear.
import led_pkg::*;
module led_fade_ch #(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tgt,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                busy
);
    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
    ch_state_t           state, state_nxt, dir;
    logic [PWM_BITS-1:0] duty, duty_nxt, eff_duty;
    logic                ramp, led_nxt;
`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq       = duty * duty;
    assign eff_duty = (duty == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign eff_duty = duty;
`endif
    // Direction is resolved from tgt first, so a coinciding fade_tick steps the new way.
    always_comb begin
        dir = state;
        if (tgt && (state == OFF || state == FALLING))
            dir = RISING;
        else if (!tgt && (state == ON || state == RISING))
            dir = FALLING;
        duty_nxt  = duty;
        state_nxt = dir;
        if (fade_tick && dir == RISING) begin
            duty_nxt  = (duty == MAX) ? duty : duty + 1'b1;
            state_nxt = (duty_nxt == MAX) ? ON : RISING;
        end else if (fade_tick && dir == FALLING) begin
            duty_nxt  = (duty == '0) ? duty : duty - 1'b1;
            state_nxt = (duty_nxt == '0) ? OFF : FALLING;
        end
        ramp    = state == RISING || state == FALLING;
        led_nxt = state == ON || (ramp && pwm_cnt < eff_duty);
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= OFF;
            duty  <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            led   <= led_nxt;
            busy  <= ramp;
        end
    end
endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: three-channel LED fader; shared prescaler, PWM counter and fade step timing.
// Build option LED_FADE_GAMMA_EN (in led_fade_ch) selects the gamma duty curve.
import led_pkg::*;
module led_fade_pwm #(
    parameter int PRESC        = DEF_PRESC,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int STEP_PERIODS = DEF_STEP_PERIODS
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] led_in,
    output logic [2:0] led_out,
    output logic [2:0] fade_busy
);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    logic [PW-1:0]       presc_cnt;
    logic [SW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          tgt;
    logic                pwm_tick, period_end, fade_tick;
    assign pwm_tick   = presc_cnt == PW'(PRESC - 1);
    assign period_end = pwm_tick && pwm_cnt == {PWM_BITS{1'b1}};
    assign fade_tick  = period_end && step_cnt == SW'(STEP_PERIODS - 1);
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            tgt       <= '0;
        end else begin
            tgt       <= led_in;
            presc_cnt <= pwm_tick ? '0 : presc_cnt + 1'b1;
            if (pwm_tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end)
                step_cnt <= fade_tick ? '0 : step_cnt + 1'b1;
        end
    end
    for (genvar i = 0; i < 3; i++) begin : g_ch
        led_fade_ch #(.PWM_BITS(PWM_BITS)) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .tgt      (tgt[i]),
            .fade_tick(fade_tick),
            .pwm_cnt  (pwm_cnt),
            .led      (led_out[i]),
            .busy     (fade_busy[i])
        );
    end
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: scoreboard bench for led_fade_pwm with PRESC=1, PWM_BITS=4, STEP_PERIODS=1.
module tb_led_fade_pwm;
  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic [2:0] busy;
    string      name;
  } exp_t;
`ifdef LED_FADE_GAMMA_EN
  localparam int H1 = 0, H4 = 1, H5 = 1, H6 = 2, H8 = 4;
`else
  localparam int H1 = 1, H4 = 4, H5 = 5, H6 = 6, H8 = 8;
`endif
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [2:0] led_in;
  logic [2:0] led_out, fade_busy;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;
  bit         done = 1'b0;
  exp_t       sb[$];
  led_fade_pwm #(.PRESC(1), .PWM_BITS(4), .STEP_PERIODS(1)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .led_in   (led_in),
    .led_out  (led_out),
    .fade_busy(fade_busy)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    while (sb.size() > 0 && (done || sb[0].cyc <= cyc)) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (done || e.cyc != cyc || led_out !== e.led || fade_busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s cyc %0d (now %0d): led_out=%b fade_busy=%b, required led_out=%b fade_busy=%b",
                 e.name, e.cyc, cyc, led_out, fade_busy, e.led, e.busy);
      end
    end
  end
  task automatic chk(input bit ok, input string n);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: led_out=%b fade_busy=%b pending=%0d",
               n, cyc, led_out, fade_busy, sb.size());
    end
  endtask
  task automatic push(input int c, input logic [2:0] l, input logic [2:0] b, input string n);
    exp_t e;
    e.cyc = c; e.led = l; e.busy = b; e.name = n;
    sb.push_back(e);
  endtask
  task automatic win(input int c, input int nh, input logic [2:0] ch, input string n);
    for (int k = 0; k < 16; k++)
      push(c + k, (k < nh) ? ch : 3'b000, ch, n);
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask
  task automatic pulse_reset(input logic [2:0] v, output int b);
    @(posedge sys_clk);
    #1;
    b = cyc;
    push(b, 3'b000, 3'b000, "reset");
    #1 sys_rst_n = 1'b0;
    #4 sys_rst_n = 1'b1;
    led_in = v;
  endtask
  initial begin
    int b;
    sys_rst_n = 1'b0;
    led_in    = 3'b000;
    #2;
    chk(led_out === 3'b000 && fade_busy === 3'b000, "reset_state");
    pulse_reset(3'b010, b);
    push(b + 2, 3'b000, 3'b000, "off_hold");
    push(b + 3, 3'b000, 3'b010, "rise_start");
    win(b + 65, H4, 3'b010, "duty4");
    win(b + 129, H8, 3'b010, "duty8");
    push(b + 240, 3'b000, 3'b010, "last_rise");
    for (int k = 241; k <= 256; k++)
      push(b + k, 3'b010, 3'b000, "on_const");
    wait_cyc(b + 260);
    led_in = 3'b000;
    push(b + 262, 3'b010, 3'b000, "on_hold");
    push(b + 263, 3'b010, 3'b010, "fall_start");
    push(b + 496, 3'b000, 3'b010, "last_fall");
    for (int k = 497; k <= 500; k++)
      push(b + k, 3'b000, 3'b000, "off_done");
    wait_cyc(b + 502);
    pulse_reset(3'b001, b);
    push(b + 3, 3'b000, 3'b001, "rise0_start");
    win(b + 97, H6, 3'b001, "duty6");
    win(b + 113, H5, 3'b001, "rev_duty5");
    push(b + 192, 3'b000, 3'b001, "rev_last");
    push(b + 193, 3'b000, 3'b000, "rev_off");
    wait_cyc(b + 100);
    led_in = 3'b000;
    wait_cyc(b + 195);
    pulse_reset(3'b100, b);
    push(b + 3, 3'b000, 3'b100, "rise2_start");
    push(b + 149, 3'b100, 3'b100, "pre_reset");
    wait_cyc(b + 149);
    pulse_reset(3'b100, b);
    push(b + 2, 3'b000, 3'b000, "restart_off");
    for (int k = 3; k <= 16; k++)
      push(b + k, 3'b000, 3'b100, "restart_duty0");
    win(b + 17, H1, 3'b100, "restart_duty1");
    wait_cyc(b + 35);
    chk(sb.size() == 0, "expired_wait");
    done = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
